// File: rtl/freqdiv_pkg.sv
// Shared types and constants for the divider ratio controller.
// The optional divide-by-1 path is enabled with FREQDIV_BYPASS_EN.
package freqdiv_pkg;

    localparam int unsigned RATIO_W_DEF = 10;
    localparam int unsigned LOAD_W_DEF  = RATIO_W_DEF - 1;

    typedef logic [RATIO_W_DEF-1:0] ratio_t;
    typedef logic [LOAD_W_DEF-1:0]  load_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    // Half-period reload for ratio n; ratios below 2 map to 0.
    function automatic load_t ratio_to_load(input ratio_t n);
        load_t half;
        half = n[RATIO_W_DEF-1:1];
        return (half == '0) ? '0 : half - LOAD_W_DEF'(1);
    endfunction

endpackage

// File: rtl/freqdiv_ratio_decode.sv
// Combinational ratio decode: N -> half-period reload, odd flag, range check.
// FREQDIV_BYPASS_EN additionally accepts N=1.
module freqdiv_ratio_decode
    import freqdiv_pkg::*;
#(
    parameter int unsigned RATIO_W   = RATIO_W_DEF,
    parameter int unsigned MIN_RATIO = 2,
    parameter int unsigned MAX_RATIO = 1023
) (
    input  logic [RATIO_W-1:0] ratio_i,
    output logic [RATIO_W-2:0] load_o,
    output logic               odd_o,
    output logic               in_range_o
);

    localparam int unsigned LOAD_W = RATIO_W - 1;
    localparam logic [RATIO_W:0] MIN_X = (RATIO_W+1)'(MIN_RATIO);
    localparam logic [RATIO_W:0] MAX_X = (RATIO_W+1)'(MAX_RATIO);

    logic [LOAD_W-1:0] half;
    logic [RATIO_W:0]  ratio_x;
    logic              is_one;

    assign half    = ratio_i[RATIO_W-1:1];
    assign ratio_x = {1'b0, ratio_i};

    // N=1 (bypass) must drive a zero reload and no odd flag.
    assign load_o = (half == '0) ? '0 : half - LOAD_W'(1);
    assign odd_o  = ratio_i[0] && (half != '0);

`ifdef FREQDIV_BYPASS_EN
    assign is_one = (ratio_i == RATIO_W'(1));
`else
    assign is_one = 1'b0;
`endif

    assign in_range_o = ((ratio_x >= MIN_X) || is_one) && (ratio_x <= MAX_X);

endmodule

// File: rtl/freqdiv_ratio_ctrl.sv
// Ratio request controller: accepts N, range-checks it, and commits the
// decoded reload at a phase_track fall. Optional N=1 bypass: FREQDIV_BYPASS_EN.
module freqdiv_ratio_ctrl
    import freqdiv_pkg::*;
#(
    parameter int unsigned RATIO_W       = RATIO_W_DEF,
    parameter int unsigned DEFAULT_RATIO = 2,
    parameter int unsigned MIN_RATIO     = 2,
    parameter int unsigned MAX_RATIO     = 1023
) (
    input  logic               clkin,
    input  logic               rst,
    input  logic [RATIO_W-1:0] ratio_in,
    input  logic               ratio_valid,
    output logic               ratio_ready,
    input  logic               phase_track,
    output logic [RATIO_W-2:0] load_value,
    output logic               rat_is_odd,
    output logic               ratio_err,
    output logic               pending,
    output logic               bypass
);

    localparam int unsigned LOAD_W = RATIO_W - 1;
    localparam logic [LOAD_W-1:0] RST_LOAD = LOAD_W'((DEFAULT_RATIO >> 1) - 1);
    localparam logic              RST_ODD  = 1'(DEFAULT_RATIO & 1);

    state_t            state_q, state_d;
    logic [LOAD_W-1:0] load_q, load_d, sh_load_q, sh_load_d;
    logic              odd_q, odd_d, sh_odd_q, sh_odd_d;
    logic              ready_q, ready_d, pend_q, pend_d, err_q, err_d;
    logic              phase_track_q;

    logic [LOAD_W-1:0] dec_load;
    logic              dec_odd, dec_in_range;
    logic              xfer_c, fall_c;

    freqdiv_ratio_decode #(
        .RATIO_W   (RATIO_W),
        .MIN_RATIO (MIN_RATIO),
        .MAX_RATIO (MAX_RATIO)
    ) u_decode (
        .ratio_i    (ratio_in),
        .load_o     (dec_load),
        .odd_o      (dec_odd),
        .in_range_o (dec_in_range)
    );

    assign xfer_c = ratio_valid && ready_q;
    assign fall_c = phase_track_q && !phase_track;

`ifdef FREQDIV_BYPASS_EN
    logic byp_q, byp_d, sh_byp_q, sh_byp_d;
`endif

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            load_q        <= RST_LOAD;
            odd_q         <= RST_ODD;
            sh_load_q     <= RST_LOAD;
            sh_odd_q      <= RST_ODD;
            ready_q       <= 1'b1;
            pend_q        <= 1'b0;
            err_q         <= 1'b0;
            phase_track_q <= 1'b0;
`ifdef FREQDIV_BYPASS_EN
            byp_q         <= 1'b0;
            sh_byp_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            load_q        <= load_d;
            odd_q         <= odd_d;
            sh_load_q     <= sh_load_d;
            sh_odd_q      <= sh_odd_d;
            ready_q       <= ready_d;
            pend_q        <= pend_d;
            err_q         <= err_d;
            phase_track_q <= phase_track;
`ifdef FREQDIV_BYPASS_EN
            byp_q         <= byp_d;
            sh_byp_q      <= sh_byp_d;
`endif
        end
    end

    // Capture legal requests into the shadow; commit on the first phase fall.
    always_comb begin
        state_d   = state_q;
        load_d    = load_q;
        odd_d     = odd_q;
        sh_load_d = sh_load_q;
        sh_odd_d  = sh_odd_q;
        err_d     = 1'b0;
`ifdef FREQDIV_BYPASS_EN
        byp_d     = byp_q;
        sh_byp_d  = sh_byp_q;
`endif
        case (state_q)
            IDLE: begin
                if (xfer_c) begin
                    if (dec_in_range) begin
                        sh_load_d = dec_load;
                        sh_odd_d  = dec_odd;
`ifdef FREQDIV_BYPASS_EN
                        sh_byp_d  = (ratio_in == RATIO_W'(1));
`endif
                        state_d   = PENDING;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            PENDING: begin
                if (fall_c) begin
                    load_d  = sh_load_q;
                    odd_d   = sh_odd_q;
`ifdef FREQDIV_BYPASS_EN
                    byp_d   = sh_byp_q;
`endif
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
        pend_d  = (state_d == PENDING);
    end

    assign ratio_ready = ready_q;
    assign load_value  = load_q;
    assign rat_is_odd  = odd_q;
    assign ratio_err   = err_q;
    assign pending     = pend_q;
`ifdef FREQDIV_BYPASS_EN
    assign bypass      = byp_q;
`else
    assign bypass      = 1'b0;
`endif

endmodule

// File: tb/tb_freqdiv_ratio_ctrl.sv
// Directed bench for freqdiv_ratio_ctrl with a behavioural segmented divider
// closing the phase_track loop. Bypass steps run when FREQDIV_BYPASS_EN is set.
`timescale 1ns/1ps
module tb_freqdiv_ratio_ctrl;

    logic       clkin = 1'b0;
    logic       rst;
    logic [9:0] ratio_in;
    logic       ratio_valid;
    logic       ratio_ready, rat_is_odd, ratio_err, pending, bypass;
    logic [8:0] load_value;

    logic [10:0] ratio_in_w;
    logic        ratio_valid_w;
    logic        ratio_ready_w, rat_is_odd_w, ratio_err_w, pending_w, bypass_w;
    logic [9:0]  load_value_w;

    logic       ph, ph_q_tb;
    logic [9:0] cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int hl;

    always #5 clkin = ~clkin;

    freqdiv_ratio_ctrl u_dut (
        .clkin       (clkin),
        .rst         (rst),
        .ratio_in    (ratio_in),
        .ratio_valid (ratio_valid),
        .ratio_ready (ratio_ready),
        .phase_track (ph),
        .load_value  (load_value),
        .rat_is_odd  (rat_is_odd),
        .ratio_err   (ratio_err),
        .pending     (pending),
        .bypass      (bypass)
    );

    freqdiv_ratio_ctrl #(
        .RATIO_W       (11),
        .DEFAULT_RATIO (2),
        .MIN_RATIO     (2),
        .MAX_RATIO     (1023)
    ) u_dut_w (
        .clkin       (clkin),
        .rst         (rst),
        .ratio_in    (ratio_in_w),
        .ratio_valid (ratio_valid_w),
        .ratio_ready (ratio_ready_w),
        .phase_track (ph),
        .load_value  (load_value_w),
        .rat_is_odd  (rat_is_odd_w),
        .ratio_err   (ratio_err_w),
        .pending     (pending_w),
        .bypass      (bypass_w)
    );

    // Divider model: toggle phase on count zero, reload half-period,
    // low half stretched by one cycle for odd ratios.
    always @(posedge clkin or posedge rst) begin
        if (rst) begin
            ph      <= 1'b0;
            ph_q_tb <= 1'b0;
            cnt     <= '0;
        end else begin
            ph_q_tb <= ph;
            if (cnt == '0) begin
                ph  <= ~ph;
                cnt <= {1'b0, load_value} + ((rat_is_odd && ph) ? 10'd1 : 10'd0);
            end else begin
                cnt <= cnt - 10'd1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic send(input logic [9:0] n);
        @(negedge clkin);
        ratio_in    = n;
        ratio_valid = 1'b1;
        @(negedge clkin);
        ratio_valid = 1'b0;
    endtask

    task automatic send_w(input logic [10:0] n);
        @(negedge clkin);
        ratio_in_w    = n;
        ratio_valid_w = 1'b1;
        @(negedge clkin);
        ratio_valid_w = 1'b0;
    endtask

    // Returns at the negedge just after the APPLY edge.
    task automatic wait_apply(input string tag);
        int i;
        i = 0;
        while (!(ph_q_tb && !ph) && i < 2200) begin
            @(negedge clkin);
            i++;
        end
        chk({tag, "_fall_seen"}, 32'(ph_q_tb && !ph), 32'd1);
        chk({tag, "_pend_before"}, 32'(pending), 32'd1);
        @(negedge clkin);
    endtask

    task automatic half_len(output int n);
        logic v;
        v = ph;
        n = 0;
        do begin
            @(negedge clkin);
            n++;
        end while (ph == v && n < 2100);
    endtask

    task automatic chk_err(input string tag, input logic [8:0] exp_load, input logic exp_odd);
        chk({tag, "_err"}, 32'(ratio_err), 32'd1);
        chk({tag, "_ready"}, 32'(ratio_ready), 32'd1);
        chk({tag, "_pend"}, 32'(pending), 32'd0);
        chk({tag, "_load"}, 32'(load_value), 32'(exp_load));
        chk({tag, "_odd"}, 32'(rat_is_odd), 32'(exp_odd));
        @(negedge clkin);
        chk({tag, "_err_drop"}, 32'(ratio_err), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        ratio_in      = '0;
        ratio_valid   = 1'b0;
        ratio_in_w    = '0;
        ratio_valid_w = 1'b0;
        repeat (3) @(negedge clkin);
        rst = 1'b0;
        @(negedge clkin);

        // Reset state and ratio-2 running
        chk("rst_load", 32'(load_value), 32'd0);
        chk("rst_odd", 32'(rat_is_odd), 32'd0);
        chk("rst_ready", 32'(ratio_ready), 32'd1);
        chk("rst_pend", 32'(pending), 32'd0);
        chk("rst_err", 32'(ratio_err), 32'd0);
        chk("rst_bypass", 32'(bypass), 32'd0);
        half_len(hl); chk("r2_half_a", 32'(hl), 32'd1);
        half_len(hl); chk("r2_half_b", 32'(hl), 32'd1);

        // 2 -> 10; first high half after APPLY still uses the old reload
        send(10'd10);
        chk("r10_pend", 32'(pending), 32'd1);
        chk("r10_ready_lo", 32'(ratio_ready), 32'd0);
        chk("r10_load_old", 32'(load_value), 32'd0);
        wait_apply("r10");
        chk("r10_load", 32'(load_value), 32'd4);
        chk("r10_odd", 32'(rat_is_odd), 32'd0);
        chk("r10_pend_clr", 32'(pending), 32'd0);
        chk("r10_ready", 32'(ratio_ready), 32'd1);
        half_len(hl); chk("r10_old_high", 32'(hl), 32'd1);
        half_len(hl); chk("r10_low", 32'(hl), 32'd5);
        half_len(hl); chk("r10_high", 32'(hl), 32'd5);

        // Same-value request goes through PENDING unchanged
        send(10'd10);
        chk("same_pend", 32'(pending), 32'd1);
        wait_apply("same");
        chk("same_load", 32'(load_value), 32'd4);
        chk("same_odd", 32'(rat_is_odd), 32'd0);

        // 10 -> 7
        send(10'd7);
        wait_apply("r7");
        chk("r7_load", 32'(load_value), 32'd2);
        chk("r7_odd", 32'(rat_is_odd), 32'd1);
        half_len(hl); chk("r7_tail_low", 32'(hl), 32'd4);
        half_len(hl); chk("r7_high", 32'(hl), 32'd3);
        half_len(hl); chk("r7_low", 32'(hl), 32'd4);

        // Out-of-range requests are consumed with a single error pulse
        send(10'd0);
        chk_err("n0", 9'd2, 1'b1);
`ifndef FREQDIV_BYPASS_EN
        send(10'd1);
        chk_err("n1", 9'd2, 1'b1);
        chk("n1_bypass", 32'(bypass), 32'd0);
`endif
        send_w(11'd1024);
        chk("w1024_err", 32'(ratio_err_w), 32'd1);
        chk("w1024_ready", 32'(ratio_ready_w), 32'd1);
        chk("w1024_pend", 32'(pending_w), 32'd0);
        chk("w1024_load", 32'(load_value_w), 32'd0);
        @(negedge clkin);
        chk("w1024_err_drop", 32'(ratio_err_w), 32'd0);

        // Upper boundary of the default width
        send(10'd1023);
        wait_apply("r1023");
        chk("r1023_load", 32'(load_value), 32'd510);
        chk("r1023_odd", 32'(rat_is_odd), 32'd1);

        // Reset while PENDING discards the shadow
        send(10'd100);
        chk("rp_pend", 32'(pending), 32'd1);
        rst = 1'b1;
        #1;
        chk("rp_load", 32'(load_value), 32'd0);
        chk("rp_odd", 32'(rat_is_odd), 32'd0);
        chk("rp_pend_clr", 32'(pending), 32'd0);
        chk("rp_ready", 32'(ratio_ready), 32'd1);
        @(negedge clkin);
        rst = 1'b0;
        @(negedge clkin);
        send(10'd100);
        wait_apply("r100");
        chk("r100_load", 32'(load_value), 32'd49);
        chk("r100_odd", 32'(rat_is_odd), 32'd0);

`ifdef FREQDIV_BYPASS_EN
        send(10'd1);
        wait_apply("byp1");
        chk("byp1_bypass", 32'(bypass), 32'd1);
        chk("byp1_load", 32'(load_value), 32'd0);
        chk("byp1_odd", 32'(rat_is_odd), 32'd0);
        send(10'd4);
        wait_apply("byp4");
        chk("byp4_bypass", 32'(bypass), 32'd0);
        chk("byp4_load", 32'(load_value), 32'd1);
        chk("byp4_odd", 32'(rat_is_odd), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
